// File: rtl/stream_mux_rr.sv
// N-channel streaming multiplexer: round-robin or fixed-select arbitration, packet-atomic
// grants, and a single registered output stage with one beat per cycle of throughput.
module stream_mux_rr #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 4,
  parameter int unsigned SELW  = 2,
  parameter int unsigned MODE  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH-1:0]       in_last,
  output logic [NCH-1:0]       in_ready,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_last,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [WIDTH-1:0] chan_data [NCH];

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    assign chan_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  logic [SELW-1:0]  ptr_q, ptr_d;
  logic             lock_q, lock_d;
  logic [SELW-1:0]  lock_ch_q, lock_ch_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_ch_q, out_ch_d;
  logic             out_last_q, out_last_d;
  logic             out_valid_q, out_valid_d;

  logic             load;
  logic             xfer;
  logic [SELW-1:0]  grant;
  logic             grant_valid;
  logic [SELW-1:0]  idx;

  // Output register is free when empty or being drained this cycle.
  assign load = !out_valid_q || out_ready;

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = '0;
    if (lock_q) begin
      grant       = lock_ch_q;
      grant_valid = in_valid[lock_ch_q];
    end else if (MODE == 0) begin
      for (int unsigned k = 0; k < NCH; k++) begin
        idx = SELW'((32'(ptr_q) + k) % NCH);
        if (!grant_valid && in_valid[idx]) begin
          grant       = idx;
          grant_valid = 1'b1;
        end
      end
    end else begin
      if (32'(sel) < NCH) begin
        grant       = sel;
        grant_valid = in_valid[sel];
      end
    end
  end

  assign xfer = !rst && load && grant_valid;

  always_comb begin
    in_ready = '0;
    if (xfer) begin
      in_ready[grant] = 1'b1;
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    lock_d      = lock_q;
    lock_ch_d   = lock_ch_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    if (load) begin
      out_valid_d = 1'b0;
      if (xfer) begin
        out_data_d  = chan_data[grant];
        out_ch_d    = grant;
        out_last_d  = in_last[grant];
        out_valid_d = 1'b1;
        if (in_last[grant]) begin
          lock_d = 1'b0;
          ptr_d  = (grant == SELW'(NCH - 1)) ? '0 : grant + 1'b1;
        end else begin
          lock_d    = 1'b1;
          lock_ch_d = grant;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      lock_q      <= 1'b0;
      lock_ch_q   <= '0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      lock_q      <= lock_d;
      lock_ch_q   <= lock_ch_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;

endmodule
